proc_io_mailbox: RTL and testbench
==================================

Name: proc_io_mailbox

Overview:
- Host-side counterpart to the RISCV32I processor's word I/O ports. Consumes the processor's OutWord1/OutWord2 and drives its InpWord1/InpWord2.
- Bridges both directions to valid/ready streams on the host side:
  - proc→host: buffered in a small FIFO.
  - host→proc: single-word offer, acknowledged by the processor.
- All processor-side signalling uses toggle handshakes, because the processor can only write and read word registers.

Parameters:
- dataW, 32, width of all data words and of the processor I/O ports.
- FifoDepth, 4, proc→host FIFO entries. Must be a power of 2 and ≥2.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- OutWord1  in  dataW  processor output data word.
- OutWord2  in  dataW  processor control word:
  - [0] tx toggle
  - [1] rx ack toggle
  - [2] overflow clear (level)
  - other bits ignored
- InpWord1  out  dataW  word offered to the processor.
- InpWord2  out  dataW  status to the processor:
  - [0] rx toggle
  - [1] FIFO full
  - [2] overflow sticky
  - other bits 0
- host_tx_data  out  dataW  FIFO head word.
- host_tx_valid  out  1  FIFO non-empty.
- host_tx_ready  in  1  host accepts head word.
- host_rx_data  in  dataW  host word for the processor.
- host_rx_valid  in  1  host word valid.
- host_rx_ready  out  1  mailbox can accept a host word.
- tx_count  out  $clog2(FifoDepth)+1  current FIFO occupancy.

Behaviour:

Reset (synchronous, reset=1 at a rising edge):
- FIFO emptied: tx_count=0, host_tx_valid=0, host_tx_data=0.
- InpWord1=0. Overflow sticky=0. RX FSM=IDLE, host_rx_ready=0 during reset.
- prev_tx ← OutWord2[0].
- InpWord2[0] ← OutWord2[1], so rx toggle and ack start equal. No spurious push or ack after a reset applied mid-operation.

TX path:
- push = (OutWord2[0] != prev_tx). prev_tx ← OutWord2[0] every cycle.
- On push, OutWord1 is written at the FIFO tail.
- pop = host_tx_valid & host_tx_ready. Head advances.
- host_tx_data is the head word, registered. Push at edge N gives host_tx_valid=1 after edge N if the FIFO was empty (1-cycle latency).
- Push while full and no pop: word dropped, overflow sticky←1, prev_tx still updated.
- Push while full with simultaneous pop: both performed, no overflow, count unchanged.
- Push and pop when count=1: both performed, count stays 1, head becomes the new word.
- Pointers wrap modulo FifoDepth.
- InpWord2[1] = (tx_count==FifoDepth).
- Overflow sticky clears when OutWord2[2]=1. If set and clear occur in the same cycle, set wins.

RX path FSM (IDLE, OFFER):
- IDLE:
  - host_rx_ready=1.
  - On host_rx_valid: InpWord1←host_rx_data, InpWord2[0] inverts, → OFFER.
- OFFER:
  - host_rx_ready=0. InpWord1 is held stable.
  - → IDLE when OutWord2[1]==InpWord2[0] (processor has acked).
  - Ack in the same cycle as entry is impossible because the comparison uses registered values.
- Minimum turnaround: one host word per 2 cycles when the processor acks immediately.

General:
- TX and RX paths are fully independent. Simultaneous events in both directions are allowed.

Decomposition:
- Package proc_io_pkg:
  - bit-index constants: TX_TOG=0, RX_ACK=1, OVF_CLR=2, RX_TOG=0, FULL=1, OVF=2.
  - rx_state_t enum {IDLE, OFFER}.
- Sub-module mailbox_fifo (sync FIFO, dataW×FifoDepth): push/pop/full/empty/count, registered head output. Instantiated once for the TX path.

Test Plan:
1. TX single word: reset; OutWord1=0xDEADBEEF, toggle OutWord2[0] 0→1, host_tx_ready=0 → next cycle host_tx_valid=1, host_tx_data=0xDEADBEEF, tx_count=1. Raise ready for 1 cycle → valid=0, count=0.
2. TX fill/overflow (FifoDepth=4): push 0x1..0x5 on consecutive toggles, ready=0 → after 4 pushes InpWord2[1]=1. Fifth push sets InpWord2[2]=1, count stays 4. Drain gives 0x1,0x2,0x3,0x4 in order. OutWord2[2]=1 for 1 cycle clears overflow.
3. Full with simultaneous push+pop: FIFO full (0xA..0xD), toggle with OutWord1=0xE while ready=1 → no overflow, count=4. Drain order 0xB,0xC,0xD,0xE.
4. RX handshake: host_rx_valid=1, data=0x12345678 → next cycle InpWord1=0x12345678, InpWord2[0]=1, host_rx_ready=0. Hold OutWord2[1]=0 for 5 cycles → stays OFFER. Set OutWord2[1]=1 → next cycle host_rx_ready=1.
5. Mid-operation reset: FIFO holding 2 words, RX in OFFER, OutWord2[1:0]=2'b11 during reset → after reset count=0, valid=0, InpWord2[0]=1, IDLE. No push occurs while OutWord2 is held.
6. Concurrent: stream 8 TX words and 8 RX words simultaneously with random ready and ack delays → all words delivered in order in both directions, no overflow.

Source files
------------

// File: rtl/proc_io_pkg.sv
// Shared constants and types for the processor I/O mailbox.
// Bit positions within the processor control/status words.
package proc_io_pkg;

    // OutWord2 (processor -> mailbox) control bits
    localparam int unsigned TX_TOG  = 0;
    localparam int unsigned RX_ACK  = 1;
    localparam int unsigned OVF_CLR = 2;

    // InpWord2 (mailbox -> processor) status bits
    localparam int unsigned RX_TOG = 0;
    localparam int unsigned FULL   = 1;
    localparam int unsigned OVF    = 2;

    typedef enum logic {
        IDLE,
        OFFER
    } rx_state_t;

endpackage

// File: rtl/proc_io_mailbox_if.sv
// Host-side valid/ready streams of the mailbox.
// master is the mailbox end, slave is the host end.
interface proc_io_mailbox_if #(
    parameter int unsigned dataW = 32
);
    logic [dataW-1:0] host_tx_data;
    logic             host_tx_valid;
    logic             host_tx_ready;
    logic [dataW-1:0] host_rx_data;
    logic             host_rx_valid;
    logic             host_rx_ready;

    modport master (
        output host_tx_data,
        output host_tx_valid,
        input  host_tx_ready,
        input  host_rx_data,
        input  host_rx_valid,
        output host_rx_ready
    );

    modport slave (
        input  host_tx_data,
        input  host_tx_valid,
        output host_tx_ready,
        output host_rx_data,
        output host_rx_valid,
        input  host_rx_ready
    );
endinterface

// File: rtl/mailbox_fifo.sv
// Synchronous FIFO with a registered head word; push while full is accepted
// only when a pop happens in the same cycle.
module mailbox_fifo #(
    parameter int unsigned dataW = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [dataW-1:0]           din,
    output logic [dataW-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);
    localparam int unsigned AW = $clog2(Depth);

    logic [dataW-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
    logic [AW:0]      count_q, count_d;
    logic [dataW-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(Depth));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr_q + AW'(1);
    assign dout    = head_q;
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // Head is kept registered, so forward the pushed word when it becomes the head.
        if (do_pop) begin
            if (count_q == (AW+1)'(1)) begin
                if (do_push) head_d = din;
            end else begin
                head_d = mem_q[rd_next];
            end
        end else if (do_push && empty) begin
            head_d = din;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_next;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/proc_io_mailbox.sv
// Host-side mailbox for the processor's word I/O ports: toggle handshakes on
// the processor side, valid/ready streams on the host side.
module proc_io_mailbox
    import proc_io_pkg::*;
#(
    parameter int unsigned dataW     = 32,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [dataW-1:0]              OutWord1,
    input  logic [dataW-1:0]              OutWord2,
    output logic [dataW-1:0]              InpWord1,
    output logic [dataW-1:0]              InpWord2,
    proc_io_mailbox_if.master             host,
    output logic [$clog2(FifoDepth):0]    tx_count
);
    // TX path
    logic prev_tx_q;
    logic ovf_q;
    logic tx_push, tx_pop, tx_full, tx_empty, tx_overflow;

    assign tx_push     = OutWord2[TX_TOG] ^ prev_tx_q;
    assign tx_pop      = host.host_tx_valid && host.host_tx_ready;
    assign tx_overflow = tx_push && tx_full && !tx_pop;
    assign host.host_tx_valid = !tx_empty;

    mailbox_fifo #(
        .dataW (dataW),
        .Depth (FifoDepth)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (OutWord1),
        .dout  (host.host_tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_tx_q <= OutWord2[TX_TOG];
            ovf_q     <= 1'b0;
        end else begin
            prev_tx_q <= OutWord2[TX_TOG];
            if (tx_overflow) begin
                ovf_q <= 1'b1;
            end else if (OutWord2[OVF_CLR]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // RX path
    rx_state_t        rx_state_q, rx_state_d;
    logic [dataW-1:0] rx_word_q;
    logic             rx_tog_q;
    logic             rx_load;

    always_comb begin
        rx_state_d         = rx_state_q;
        rx_load            = 1'b0;
        host.host_rx_ready = 1'b0;
        unique case (rx_state_q)
            IDLE: begin
                host.host_rx_ready = !reset;
                if (host.host_rx_valid && !reset) begin
                    rx_load    = 1'b1;
                    rx_state_d = OFFER;
                end
            end
            OFFER: begin
                if (OutWord2[RX_ACK] == rx_tog_q) rx_state_d = IDLE;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= IDLE;
            rx_word_q  <= '0;
            // Start with toggle equal to ack so a reset never looks like a new offer.
            rx_tog_q   <= OutWord2[RX_ACK];
        end else begin
            rx_state_q <= rx_state_d;
            if (rx_load) begin
                rx_word_q <= host.host_rx_data;
                rx_tog_q  <= !rx_tog_q;
            end
        end
    end

    assign InpWord1 = rx_word_q;

    always_comb begin
        InpWord2         = '0;
        InpWord2[RX_TOG] = rx_tog_q;
        InpWord2[FULL]   = tx_full;
        InpWord2[OVF]    = ovf_q;
    end

    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^OutWord2[dataW-1:3];

endmodule

// File: tb/tb_proc_io_mailbox.sv
// Directed self-checking bench for proc_io_mailbox.
module tb_proc_io_mailbox;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clock;
    logic          reset;
    logic [DW-1:0] ow1, ow2;
    logic [DW-1:0] iw1, iw2;
    logic [2:0]    tx_count;

    int checks;
    int errors;

    proc_io_mailbox_if #(.dataW(DW)) hif ();

    proc_io_mailbox #(
        .dataW     (DW),
        .FifoDepth (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .OutWord1 (ow1),
        .OutWord2 (ow2),
        .InpWord1 (iw1),
        .InpWord2 (iw2),
        .host     (hif.master),
        .tx_count (tx_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tx_push(input logic [DW-1:0] data);
        ow1     = data;
        ow2[0]  = ~ow2[0];
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ow1 = '0;
        ow2 = '0;
        hif.host_tx_ready = 1'b0;
        hif.host_rx_valid = 1'b0;
        hif.host_rx_data  = '0;
        step();
        step();
        checks++;
        if (hif.host_rx_ready !== 1'b0) begin
            errors++; $display("FAIL reset_rx_ready: got %0b want 0", hif.host_rx_ready);
        end
        reset = 1'b0;
        step();
        checks++;
        if (tx_count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", tx_count);
        end
        checks++;
        if (hif.host_tx_valid !== 1'b0 || hif.host_tx_data !== '0) begin
            errors++; $display("FAIL reset_tx: got valid %0b data %h want 0/0",
                               hif.host_tx_valid, hif.host_tx_data);
        end
        checks++;
        if (iw1 !== '0 || iw2 !== '0) begin
            errors++; $display("FAIL reset_inp: got %h %h want 0 0", iw1, iw2);
        end
        checks++;
        if (hif.host_rx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle_ready: got %0b want 1", hif.host_rx_ready);
        end
    endtask

    task automatic test_tx_single();
        tx_push(32'hDEADBEEF);
        checks++;
        if (hif.host_tx_valid !== 1'b1 || hif.host_tx_data !== 32'hDEADBEEF || tx_count !== 3'd1)
        begin
            errors++; $display("FAIL tx_single: got v%0b %h c%0d want v1 deadbeef c1",
                               hif.host_tx_valid, hif.host_tx_data, tx_count);
        end
        hif.host_tx_ready = 1'b1;
        step();
        hif.host_tx_ready = 1'b0;
        checks++;
        if (hif.host_tx_valid !== 1'b0 || tx_count !== 3'd0) begin
            errors++; $display("FAIL tx_single_pop: got v%0b c%0d want v0 c0",
                               hif.host_tx_valid, tx_count);
        end
    endtask

    task automatic test_tx_overflow();
        for (int i = 1; i <= 4; i++) tx_push(DW'(i));
        checks++;
        if (iw2[1] !== 1'b1 || iw2[2] !== 1'b0 || tx_count !== 3'd4) begin
            errors++; $display("FAIL ovf_full: got full %0b ovf %0b c%0d want 1 0 4",
                               iw2[1], iw2[2], tx_count);
        end
        tx_push(32'h5);
        checks++;
        if (iw2[2] !== 1'b1 || tx_count !== 3'd4) begin
            errors++; $display("FAIL ovf_set: got ovf %0b c%0d want 1 4", iw2[2], tx_count);
        end
        hif.host_tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (hif.host_tx_valid !== 1'b1 || hif.host_tx_data !== DW'(i)) begin
                errors++; $display("FAIL ovf_drain%0d: got v%0b %h want v1 %h",
                                   i, hif.host_tx_valid, hif.host_tx_data, DW'(i));
            end
            step();
        end
        hif.host_tx_ready = 1'b0;
        checks++;
        if (hif.host_tx_valid !== 1'b0 || iw2[2] !== 1'b1) begin
            errors++; $display("FAIL ovf_after_drain: got v%0b ovf %0b want v0 ovf1",
                               hif.host_tx_valid, iw2[2]);
        end
        ow2[2] = 1'b1;
        step();
        ow2[2] = 1'b0;
        checks++;
        if (iw2[2] !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %0b want 0", iw2[2]);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_q [4];
        exp_q = '{32'hB, 32'hC, 32'hD, 32'hE};
        for (int i = 0; i < 4; i++) tx_push(DW'(32'hA + i));
        hif.host_tx_ready = 1'b1;
        tx_push(32'hE);
        checks++;
        if (tx_count !== 3'd4 || iw2[2] !== 1'b0) begin
            errors++; $display("FAIL full_pushpop: got c%0d ovf %0b want c4 ovf0",
                               tx_count, iw2[2]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hif.host_tx_valid !== 1'b1 || hif.host_tx_data !== exp_q[i]) begin
                errors++; $display("FAIL full_drain%0d: got v%0b %h want v1 %h",
                                   i, hif.host_tx_valid, hif.host_tx_data, exp_q[i]);
            end
            step();
        end
        hif.host_tx_ready = 1'b0;
        checks++;
        if (tx_count !== 3'd0 || iw2[2] !== 1'b0) begin
            errors++; $display("FAIL full_end: got c%0d ovf %0b want 0 0", tx_count, iw2[2]);
        end
    endtask

    task automatic test_rx();
        hif.host_rx_valid = 1'b1;
        hif.host_rx_data  = 32'h12345678;
        checks++;
        if (hif.host_rx_ready !== 1'b1) begin
            errors++; $display("FAIL rx_idle_ready: got %0b want 1", hif.host_rx_ready);
        end
        step();
        hif.host_rx_valid = 1'b0;
        hif.host_rx_data  = 32'hFFFF0000;
        checks++;
        if (iw1 !== 32'h12345678 || iw2[0] !== 1'b1 || hif.host_rx_ready !== 1'b0) begin
            errors++; $display("FAIL rx_offer: got %h tog %0b rdy %0b want 12345678 1 0",
                               iw1, iw2[0], hif.host_rx_ready);
        end
        repeat (5) step();
        checks++;
        if (hif.host_rx_ready !== 1'b0 || iw1 !== 32'h12345678) begin
            errors++; $display("FAIL rx_hold: got rdy %0b %h want 0 12345678",
                               hif.host_rx_ready, iw1);
        end
        ow2[1] = 1'b1;
        step();
        checks++;
        if (hif.host_rx_ready !== 1'b1) begin
            errors++; $display("FAIL rx_ack: got rdy %0b want 1", hif.host_rx_ready);
        end
    endtask

    task automatic test_mid_reset();
        tx_push(32'h77);
        tx_push(32'h88);
        hif.host_rx_valid = 1'b1;
        hif.host_rx_data  = 32'hCAFE;
        step();
        hif.host_rx_valid = 1'b0;
        checks++;
        if (tx_count !== 3'd2 || hif.host_rx_ready !== 1'b0 || iw2[0] !== 1'b0) begin
            errors++; $display("FAIL mid_pre: got c%0d rdy %0b tog %0b want 2 0 0",
                               tx_count, hif.host_rx_ready, iw2[0]);
        end
        reset = 1'b1;
        ow2[1:0] = 2'b11;
        step();
        checks++;
        if (hif.host_rx_ready !== 1'b0) begin
            errors++; $display("FAIL mid_during: got rdy %0b want 0", hif.host_rx_ready);
        end
        reset = 1'b0;
        step();
        checks++;
        if (tx_count !== 3'd0 || hif.host_tx_valid !== 1'b0 || iw2[0] !== 1'b1 ||
            hif.host_rx_ready !== 1'b1) begin
            errors++; $display("FAIL mid_after: got c%0d v%0b tog %0b rdy %0b want 0 0 1 1",
                               tx_count, hif.host_tx_valid, iw2[0], hif.host_rx_ready);
        end
        repeat (3) step();
        checks++;
        if (tx_count !== 3'd0 || hif.host_rx_ready !== 1'b1) begin
            errors++; $display("FAIL mid_quiet: got c%0d rdy %0b want 0 1",
                               tx_count, hif.host_rx_ready);
        end
    endtask

    task automatic test_concurrent();
        logic [DW-1:0] tx_exp [$];
        int tx_sent = 0, tx_got = 0, occ = 0;
        int rx_idx = 0, rx_got = 0, ack_wait = 0;
        bit accepted = 0;
        bit rdy, psh;
        for (int cyc = 0; cyc < 400; cyc++) begin
            // host receives from TX FIFO
            checks++;
            if (hif.host_tx_valid !== (occ > 0)) begin
                errors++; $display("FAIL conc_valid c%0d: got %0b want %0b",
                                   cyc, hif.host_tx_valid, occ > 0);
            end
            rdy = ($urandom_range(0, 2) != 0);
            if (rdy && occ > 0) begin
                checks++;
                if (hif.host_tx_data !== tx_exp[0]) begin
                    errors++; $display("FAIL conc_tx%0d: got %h want %h",
                                       tx_got, hif.host_tx_data, tx_exp[0]);
                end
                void'(tx_exp.pop_front());
                occ--;
                tx_got++;
            end
            hif.host_tx_ready = rdy;
            // processor pushes while it knows there is room
            psh = (tx_sent < 8) && ($urandom_range(0, 1) == 1) && (occ < int'(DEPTH));
            if (psh) begin
                ow1    = 32'h100 + DW'(tx_sent);
                ow2[0] = ~ow2[0];
                tx_exp.push_back(ow1);
                tx_sent++;
                occ++;
            end
            // processor side of RX
            if (iw2[0] != ow2[1]) begin
                if (ack_wait == 0) begin
                    checks++;
                    if (iw1 !== 32'hA000 + DW'(rx_got * 3)) begin
                        errors++; $display("FAIL conc_rx%0d: got %h want %h",
                                           rx_got, iw1, 32'hA000 + DW'(rx_got * 3));
                    end
                    rx_got++;
                    ow2[1]   = ~ow2[1];
                    ack_wait = $urandom_range(0, 3);
                end else begin
                    ack_wait--;
                end
            end
            // host side of RX
            if (accepted) begin
                rx_idx++;
                hif.host_rx_valid = 1'b0;
            end
            if (!hif.host_rx_valid && rx_idx < 8 && $urandom_range(0, 1) == 1) begin
                hif.host_rx_valid = 1'b1;
                hif.host_rx_data  = 32'hA000 + DW'(rx_idx * 3);
            end
            accepted = hif.host_rx_valid && hif.host_rx_ready;
            step();
            if (tx_got == 8 && rx_got == 8 && !accepted) break;
        end
        hif.host_tx_ready = 1'b0;
        hif.host_rx_valid = 1'b0;
        checks++;
        if (tx_got != 8 || rx_got != 8) begin
            errors++; $display("FAIL conc_done: got tx %0d rx %0d want 8 8", tx_got, rx_got);
        end
        checks++;
        if (iw2[2] !== 1'b0 || tx_count !== 3'd0) begin
            errors++; $display("FAIL conc_end: got ovf %0b c%0d want 0 0", iw2[2], tx_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_tx_single();
        test_tx_overflow();
        test_full_push_pop();
        test_rx();
        test_mid_reset();
        test_concurrent();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
